coin_toss_gen: RTL and testbench
================================

# coin_toss_gen

Pseudo-random coin-toss source that sits directly upstream of the coin-toss tracker. It drives that stage's 1-bit toss input (`oe`). A Galois LFSR produces the toss bits. A pacing counter issues one toss every `PERIOD` cycles for a burst of `num_tosses` tosses, and a small FSM manages the seed load, burst start, abort and completion.

## Interface
- `LFSR_W`, 16: LFSR width; must be ≥ 8. Feedback mask is 16'hB400 when `LFSR_W` = 16.
- `PERIOD`, 6: cycles per toss; must be ≥ 1.
- `CNT_W`, 8: width of the burst counter.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `seed_ld`  in  1  loads `seed` into the LFSR; honoured in IDLE only.
- `seed`  in  LFSR_W  seed value.
- `start`  in  1  starts a burst; honoured in IDLE only.
- `num_tosses`  in  CNT_W  burst length, sampled together with `start`.
- `stop`  in  1  synchronous abort.
- `bias`  in  8  heads threshold; present only with `COIN_BIAS_EN`.
- `toss`  out  1  current toss bit (1 = heads); feeds the downstream `oe`.
- `toss_vld`  out  1  one-cycle pulse when `toss` updates.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a burst completes.
- `tosses_left`  out  CNT_W  tosses remaining in the current burst.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `seed_ld`: LFSR ← `seed`. An all-zero seed is replaced by all-ones.
  - `start` with `num_tosses` ≠ 0: go to RUN; `tosses_left` ← `num_tosses`; pace counter ← 0.
  - `start` with `num_tosses` = 0: go to DONE directly.
  - `seed_ld` and `start` together: the seed loads and the burst starts. The first toss uses the new seed.
- RUN:
  - The pace counter runs 0 … `PERIOD`−1.
  - The LFSR holds its value except on toss edges.
  - On each edge with pace = `PERIOD`−1:
    - `toss` ← toss bit from the current (pre-step) LFSR value.
    - `toss_vld` ← 1.
    - LFSR steps once.
    - `tosses_left` decrements.
    - Pace counter wraps to 0.
  - When `tosses_left` goes from 1 to 0, the FSM moves to DONE on that same edge.
  - `start` and `seed_ld` are ignored in RUN.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- LFSR step (Galois, shift right): next = (lfsr >> 1) ^ (lfsr[0] ? MASK : 0).
- `stop` (any state other than IDLE):
  - FSM → IDLE; `tosses_left` ← 0; pace counter ← 0.
  - No `done` pulse and no `toss_vld` pulse that cycle, even if the toss edge coincides with `stop`.
  - `stop` has priority over everything except reset.
- `toss` holds its last value between pulses and while in IDLE.
- `busy` = 1 exactly when the FSM is in RUN.

## Timing
- Reset values:
  - FSM = IDLE
  - LFSR = all-ones
  - `toss`, `toss_vld`, `busy`, `done` = 0
  - `tosses_left` = 0
  - pace counter = 0
- Reset asserted mid-burst: all of the above apply immediately, asynchronously.
- `start` sampled at edge k:
  - `busy` is high from k+1.
  - First `toss_vld` appears after edge k+`PERIOD`; later pulses follow every `PERIOD` cycles.
- For `PERIOD` = 1, `toss_vld` is high continuously for the whole burst.
- `done` appears in the cycle after the last `toss_vld`. A new `start` is accepted the cycle after `done`.
- Burst with `num_tosses` = 0: `done` appears the cycle after `start`; no `toss_vld`.
- Every output is registered; there is no combinational path from input to output.

## Configuration
- `COIN_BIAS_EN` defined:
  - The `bias` port exists.
  - Toss bit = (lfsr[7:0] < `bias`). `bias` = 0 gives all tails; `bias` = 128 gives about 50 % heads.
  - `bias` is sampled at each toss edge.
- `COIN_BIAS_EN` undefined:
  - No `bias` port.
  - Toss bit = lfsr[0].

## Test plan
- Seed 16'h0001, `PERIOD` = 1, `num_tosses` = 12, no bias → `toss` sequence 1,0,0,0,0,0,0,0,0,0,0,1 on 12 consecutive `toss_vld` cycles; `done` the cycle after the last one.
- `PERIOD` = 6, `num_tosses` = 3 → `toss_vld` at 6, 12 and 18 cycles after the `start` edge; `tosses_left` steps 3→2→1→0; `busy` falls together with the `done` pulse.
- Seed 16'h0000 → behaves identically to seed 16'hFFFF, so the first toss is 1; `start` with `num_tosses` = 0 → `done` the next cycle with no `toss_vld`.
- `stop` asserted on the edge of the 2nd toss of a 5-toss burst → only 1 `toss_vld` total; no `done`; `tosses_left` = 0; FSM in IDLE; `start` and `seed_ld` pulsed during RUN are ignored.
- `rst` driven low mid-burst, asynchronously between clock edges → all outputs 0 immediately; after release the LFSR is all-ones and the first toss is 1.
- `COIN_BIAS_EN` with `bias` = 0 → 20 tosses all 0; with `bias` = 8'hFF and seed 16'h00FF, the first toss is 0 and later tosses are 1 unless lfsr[7:0] = 8'hFF.

Source files
------------

// File: rtl/coin_toss_gen.sv
// Paced Galois-LFSR coin-toss burst generator feeding the tracker's toss input.
// Optional `COIN_BIAS_EN` adds an 8-bit heads threshold port (bias).
module coin_toss_gen #(
    parameter int LFSR_W = 16,
    parameter int PERIOD = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_ld,
    input  logic [LFSR_W-1:0] seed,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_tosses,
    input  logic              stop,
`ifdef COIN_BIAS_EN
    input  logic [7:0]        bias,
`endif
    output logic              toss,
    output logic              toss_vld,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tosses_left
);

    // 16'hB400 is the maximal-length tap set for 16 bits; other widths fall back to a single top tap.
    localparam logic [LFSR_W-1:0] FB_MASK = (LFSR_W == 16) ? LFSR_W'(16'hB400)
                                                            : (LFSR_W'(1'b1) << (LFSR_W - 1));
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PACE_LAST = PW'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [PW-1:0]     pace_q;
    logic              abort, toss_edge, last_toss, toss_bit;
    logic [LFSR_W-1:0] lfsr_step, seed_fixed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_tosses == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_toss) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        abort      = stop && (state_q != S_IDLE);
        toss_edge  = (state_q == S_RUN) && (pace_q == PACE_LAST) && !stop;
        last_toss  = toss_edge && (tosses_left == CNT_W'(1));
        lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? FB_MASK : '0);
        seed_fixed = (seed == '0) ? '1 : seed;
`ifdef COIN_BIAS_EN
        toss_bit   = (lfsr_q[7:0] < bias);
`else
        toss_bit   = lfsr_q[0];
`endif
    end

    // busy/done are registered copies of the state, so both trail it by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q      <= '1;
            pace_q      <= '0;
            tosses_left <= '0;
            toss        <= 1'b0;
            toss_vld    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            toss_vld <= toss_edge;
            busy     <= (state_q == S_RUN) && !stop;
            done     <= (state_q == S_DONE) && !stop;
            if (state_q == S_IDLE && seed_ld) lfsr_q <= seed_fixed;
            else if (toss_edge)               lfsr_q <= lfsr_step;
            if (toss_edge) toss <= toss_bit;
            if (abort) begin
                pace_q      <= '0;
                tosses_left <= '0;
            end else if (state_q == S_IDLE) begin
                pace_q <= '0;
                if (start) tosses_left <= num_tosses;
            end else if (state_q == S_RUN) begin
                pace_q <= (pace_q == PACE_LAST) ? '0 : pace_q + 1'b1;
                if (toss_edge) tosses_left <= tosses_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coin_toss_gen.sv
// Bench for coin_toss_gen: instance 0 runs PERIOD=6, instance 1 runs PERIOD=1.
module tb_coin_toss_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v[2], seed_ld_v[2], stop_v[2];
    logic [15:0] seed_v[2];
    logic [7:0]  num_v[2];
    logic        toss_o[2], vld_o[2], busy_o[2], done_o[2];
    logic [7:0]  left_o[2];
    logic [7:0]  bias;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_lfsr[2];
    logic        m_toss[2];

    always #5 clk = ~clk;

    coin_toss_gen #(.LFSR_W(16), .PERIOD(6), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .seed_ld(seed_ld_v[0]), .seed(seed_v[0]),
        .start(start_v[0]), .num_tosses(num_v[0]), .stop(stop_v[0]),
`ifdef COIN_BIAS_EN
        .bias(bias),
`endif
        .toss(toss_o[0]), .toss_vld(vld_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .tosses_left(left_o[0])
    );

    coin_toss_gen #(.LFSR_W(16), .PERIOD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .seed_ld(seed_ld_v[1]), .seed(seed_v[1]),
        .start(start_v[1]), .num_tosses(num_v[1]), .stop(stop_v[1]),
`ifdef COIN_BIAS_EN
        .bias(bias),
`endif
        .toss(toss_o[1]), .toss_vld(vld_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .tosses_left(left_o[1])
    );

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic tbit(input logic [15:0] l);
`ifdef COIN_BIAS_EN
        return (l[7:0] < bias);
`else
        return l[0];
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 16'hFFFF;
            m_toss[i] = 1'b0;
        end
    endtask

    // Start a burst on one instance and compare every cycle against a timeline model.
    // stop_edge: edge number (start edge = 0) on which stop is sampled, 0 = none.
    task automatic run_burst(input int idx, input bit do_seed, input logic [15:0] sd,
                             input int n, input int stop_edge, input bit poke,
                             output logic [31:0] seq, output int nv);
        int  p, k;
        bit  stopped, fire, eb, ed;
        int  el;
        p   = (idx == 0) ? 6 : 1;
        seq = '0;
        nv  = 0;
        @(negedge clk);
        start_v[idx]   = 1'b1;
        num_v[idx]     = 8'(n);
        seed_ld_v[idx] = do_seed;
        seed_v[idx]    = sd;
        if (do_seed) m_lfsr[idx] = (sd == 16'h0) ? 16'hFFFF : sd;
        @(posedge clk);
        #1;
        start_v[idx]   = 1'b0;
        seed_ld_v[idx] = 1'b0;
        for (int c = 0; c <= n * p + 3; c++) begin
            @(negedge clk);
            stopped = (stop_edge > 0) && (c >= stop_edge);
            k       = c / p;
            fire    = !stopped && (c % p == 0) && (k >= 1) && (k <= n);
            eb      = !stopped && (c >= 1) && (c <= n * p);
            ed      = !stopped && (c == n * p + 1);
            el      = stopped ? 0 : n - ((k < n) ? k : n);
            if (fire) begin
                m_toss[idx] = tbit(m_lfsr[idx]);
                m_lfsr[idx] = lstep(m_lfsr[idx]);
            end
            if (vld_o[idx]) begin
                seq = {seq[30:0], toss_o[idx]};
                nv++;
            end
            checks += 5;
            if (vld_o[idx] !== fire) begin
                failures++;
                $display("FAIL toss_vld dut%0d c=%0d got=%b exp=%b", idx, c, vld_o[idx], fire);
            end
            if (busy_o[idx] !== eb) begin
                failures++;
                $display("FAIL busy dut%0d c=%0d got=%b exp=%b", idx, c, busy_o[idx], eb);
            end
            if (done_o[idx] !== ed) begin
                failures++;
                $display("FAIL done dut%0d c=%0d got=%b exp=%b", idx, c, done_o[idx], ed);
            end
            if (left_o[idx] !== 8'(el)) begin
                failures++;
                $display("FAIL tosses_left dut%0d c=%0d got=%0d exp=%0d", idx, c, left_o[idx], el);
            end
            if (toss_o[idx] !== m_toss[idx]) begin
                failures++;
                $display("FAIL toss dut%0d c=%0d got=%b exp=%b", idx, c, toss_o[idx], m_toss[idx]);
            end
            stop_v[idx] = (stop_edge > 0) && (c + 1 == stop_edge);
            if (poke && c + 1 == 2) begin
                start_v[idx]   = 1'b1;
                seed_ld_v[idx] = 1'b1;
                seed_v[idx]    = 16'($urandom);
                num_v[idx]     = 8'($urandom_range(1, 9));
            end
            @(posedge clk);
            #1;
            stop_v[idx]    = 1'b0;
            start_v[idx]   = 1'b0;
            seed_ld_v[idx] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({toss_o[i], vld_o[i], busy_o[i], done_o[i], left_o[i]} !== 12'h0) begin
                failures++;
                $display("FAIL %s dut%0d got toss=%b vld=%b busy=%b done=%b left=%0d exp all 0",
                         tag, i, toss_o[i], vld_o[i], busy_o[i], done_o[i], left_o[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; seed_ld_v[i] = 1'b0; stop_v[i] = 1'b0;
            seed_v[i] = 16'h0; num_v[i] = 8'h0;
        end
        bias = 8'd128;
        model_reset();
        #1;
        check_all_zero("reset_values");
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_period1_sequence();
        logic [31:0] seq; int nv;
        run_burst(1, 1'b1, 16'h0001, 12, 0, 1'b0, seq, nv);
        checks++;
        if (nv !== 12) begin
            failures++;
            $display("FAIL p1_count got=%0d exp=12", nv);
        end
`ifndef COIN_BIAS_EN
        checks++;
        if (seq[11:0] !== 12'b1000_0000_0001) begin
            failures++;
            $display("FAIL p1_sequence got=%b exp=100000000001", seq[11:0]);
        end
`endif
    endtask

    task automatic test_period6();
        logic [31:0] seq; int nv;
        run_burst(0, 1'b1, 16'($urandom), 3, 0, 1'b0, seq, nv);
        checks++;
        if (nv !== 3) begin
            failures++;
            $display("FAIL p6_count got=%0d exp=3", nv);
        end
    endtask

    task automatic test_zero_seed_and_empty();
        logic [31:0] seq; int nv;
        run_burst(0, 1'b1, 16'h0000, 2, 0, 1'b0, seq, nv);
`ifndef COIN_BIAS_EN
        checks++;
        if (seq[1] !== 1'b1) begin
            failures++;
            $display("FAIL zero_seed_first got=%b exp=1", seq[1]);
        end
`endif
        run_burst(0, 1'b0, 16'h0, 0, 0, 1'b0, seq, nv);
        run_burst(1, 1'b0, 16'h0, 0, 0, 1'b0, seq, nv);
        checks++;
        if (nv !== 0) begin
            failures++;
            $display("FAIL empty_burst_vld got=%0d exp=0", nv);
        end
    endtask

    task automatic test_stop();
        logic [31:0] seq; int nv;
        run_burst(0, 1'b1, 16'($urandom), 5, 12, 1'b1, seq, nv);
        checks++;
        if (nv !== 1) begin
            failures++;
            $display("FAIL stop_vld_count got=%0d exp=1", nv);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] seq; int nv;
        @(negedge clk);
        start_v[0] = 1'b1;
        num_v[0]   = 8'd5;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_burst(0, 1'b0, 16'h0, 3, 0, 1'b0, seq, nv);
`ifndef COIN_BIAS_EN
        checks++;
        if (seq[2] !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_first got=%b exp=1", seq[2]);
        end
`endif
    endtask

`ifdef COIN_BIAS_EN
    task automatic test_bias();
        logic [31:0] seq; int nv;
        bias = 8'd0;
        run_burst(1, 1'b1, 16'($urandom), 20, 0, 1'b0, seq, nv);
        checks++;
        if (seq[19:0] !== 20'h0 || nv !== 20) begin
            failures++;
            $display("FAIL bias0 got=%h n=%0d exp=00000 n=20", seq[19:0], nv);
        end
        bias = 8'hFF;
        run_burst(0, 1'b1, 16'h00FF, 4, 0, 1'b0, seq, nv);
        checks++;
        if (seq[3] !== 1'b0) begin
            failures++;
            $display("FAIL biasff_first got=%b exp=0", seq[3]);
        end
        bias = 8'd128;
    endtask
`endif

    task automatic test_random();
        logic [31:0] seq; int nv, idx;
        for (int r = 0; r < 6; r++) begin
            idx = int'($urandom_range(0, 1));
`ifdef COIN_BIAS_EN
            bias = 8'($urandom);
`endif
            run_burst(idx, 1'($urandom_range(0, 1)), 16'($urandom),
                      int'($urandom_range(1, 10)), 0, 1'b0, seq, nv);
        end
    endtask

    initial begin
        test_reset();
        test_period1_sequence();
        test_period6();
        test_zero_seed_and_empty();
        test_stop();
        test_async_reset();
`ifdef COIN_BIAS_EN
        test_bias();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
